// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: fetch FSM encoding, reset/NOP defaults and base opcodes
// used by the fetch stage and the control unit.
package rv32i_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RV_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] RV_NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/instruction_fetch.sv
// RV32I instruction fetch stage: one outstanding request, holds the fetched word
// until decode accepts it, and drops in-flight responses made stale by a redirect.
module instruction_fetch
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RV_RESET_PC,
  parameter logic [31:0] NOP_INSTR = RV_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic [4:0]  rd,
  output logic [2:0]  funct3,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [6:0]  funct7
);

  fetch_state_t state;
  fetch_state_t state_next;
  logic [31:0]  pending_pc;
  logic [31:0]  pending_pc_next;
  logic [31:0]  pc_next;
  logic [31:0]  instr_next;
  logic         valid_next;
  logic [31:0]  target_pc;

  // Gated by reset directly so the request rises in the very first cycle after release.
  assign imem_req  = !reset && (state != HOLD);
  assign imem_addr = pc;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  assign target_pc = word_align(redirect_pc);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      pending_pc <= RESET_PC;
      instr      <= NOP_INSTR;
      valid      <= 1'b0;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      pending_pc <= pending_pc_next;
      instr      <= instr_next;
      valid      <= valid_next;
    end
  end

  // Next-state and datapath update rules
  always_comb begin
    state_next      = state;
    pc_next         = pc;
    pending_pc_next = pending_pc;
    instr_next      = instr;
    valid_next      = valid;
    case (state)
      FETCH: begin
        if (imem_ready) begin
          if (redirect) begin
            pc_next = target_pc;
          end else begin
            instr_next = imem_rdata;
            valid_next = 1'b1;
            state_next = HOLD;
          end
        end else if (redirect) begin
          pending_pc_next = target_pc;
          state_next      = DROP;
        end else begin
          state_next = FETCH;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_next    = target_pc;
          valid_next = 1'b0;
          instr_next = NOP_INSTR;
          state_next = FETCH;
        end else if (!stall) begin
          pc_next    = pc + 32'd4;
          valid_next = 1'b0;
          instr_next = NOP_INSTR;
          state_next = FETCH;
        end else begin
          state_next = HOLD;
        end
      end
      DROP: begin
        // The newest redirect target wins even when it lands with the stale response.
        if (redirect) begin
          pending_pc_next = target_pc;
        end else begin
          pending_pc_next = pending_pc;
        end
        if (imem_ready) begin
          pc_next    = pending_pc_next;
          state_next = FETCH;
        end else begin
          state_next = DROP;
        end
      end
      default: begin
        state_next = FETCH;
        valid_next = 1'b0;
        instr_next = NOP_INSTR;
      end
    endcase
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed and randomized checks of instruction_fetch against a transaction-level
// reference model of the fetch rules.
module tb_instruction_fetch;

  localparam logic [31:0] EXP_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] EXP_NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        valid;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: is an instruction being held, is a stale response being waited out.
  bit          m_holding;
  bit          m_discard;
  logic [31:0] m_pc;
  logic [31:0] m_target;
  logic [31:0] m_instr;
  bit          m_valid;

  instruction_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .valid       (valid),
    .pc          (pc),
    .instr       (instr),
    .opcode      (opcode),
    .rd          (rd),
    .funct3      (funct3),
    .rs1         (rs1),
    .rs2         (rs2),
    .funct7      (funct7)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_holding = 1'b0;
    m_discard = 1'b0;
    m_pc      = EXP_RESET_PC;
    m_target  = EXP_RESET_PC;
    m_instr   = EXP_NOP;
    m_valid   = 1'b0;
  endtask

  // One clock: drive at negedge, check request side, clock, update model, check held outputs.
  task automatic step(input logic r, input logic st, input logic rdr, input logic rdy,
                      input logic [31:0] rdata, input logic [31:0] rpc);
    logic [31:0] tgt;
    reset       = r;
    stall       = st;
    redirect    = rdr;
    imem_ready  = rdy;
    imem_rdata  = rdata;
    redirect_pc = rpc;
    #1;
    chk("imem_req", {31'd0, imem_req}, {31'd0, (!r && !m_holding)});
    chk("imem_addr", imem_addr, m_pc);
    @(posedge clk);
    tgt = {rpc[31:2], 2'b00};
    if (r) begin
      model_reset();
    end else if (m_holding) begin
      if (rdr || !st) begin
        m_pc      = rdr ? tgt : m_pc + 32'd4;
        m_valid   = 1'b0;
        m_instr   = EXP_NOP;
        m_holding = 1'b0;
      end
    end else if (m_discard) begin
      if (rdr) m_target = tgt;
      if (rdy) begin
        m_pc      = m_target;
        m_discard = 1'b0;
      end
    end else if (rdy) begin
      if (rdr) begin
        m_pc = tgt;
      end else begin
        m_instr   = rdata;
        m_valid   = 1'b1;
        m_holding = 1'b1;
      end
    end else if (rdr) begin
      m_target  = tgt;
      m_discard = 1'b1;
    end
    @(negedge clk);
    chk("valid", {31'd0, valid}, {31'd0, m_valid});
    chk("pc", pc, m_pc);
    chk("instr", instr, m_instr);
    chk("fields", {opcode, rd, funct3, rs1, rs2, funct7},
        {m_instr[6:0], m_instr[11:7], m_instr[14:12], m_instr[19:15], m_instr[24:20], m_instr[31:25]});
  endtask

  initial begin
    reset       = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    imem_ready  = 1'b0;
    imem_rdata  = 32'd0;
    redirect_pc = 32'd0;
    model_reset();
    repeat (2) @(negedge clk);

    // Reset state, then straight-line fetch with immediate ready
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("reset_valid", {31'd0, valid}, 32'd0);
    chk("reset_instr", instr, EXP_NOP);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0020_81B3, 32'd0);
    chk("opcode_r_type", {25'd0, opcode}, {25'd0, 7'b0110011});
    chk("valid_after_ready", {31'd0, valid}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, $urandom, 32'd0);
    chk("addr_4", imem_addr, 32'h0000_0004);
    step(1'b0, 1'b0, 1'b0, 1'b1, $urandom, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, $urandom, 32'd0);
    chk("addr_8", imem_addr, 32'h0000_0008);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 32'd0);

    // Stalled hold; stray ready must be ignored
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0, i[0], $urandom, 32'd0);
      chk("stall_instr", instr, 32'h1234_5678);
      chk("stall_pc", pc, 32'h0000_0008);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, $urandom, 32'd0);

    // Redirect with the response delayed: stale word dropped
    step(1'b0, 1'b0, 1'b1, 1'b0, $urandom, 32'h0000_0103);
    step(1'b0, 1'b0, 1'b0, 1'b0, $urandom, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, $urandom, 32'd0);
    chk("drop_old_addr", imem_addr, 32'h0000_000C);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'd0);
    chk("drop_new_addr", imem_addr, 32'h0000_0100);
    chk("drop_no_valid", {31'd0, valid}, 32'd0);

    // Redirect coincident with ready
    step(1'b0, 1'b0, 1'b1, 1'b1, $urandom, 32'h0000_0200);
    chk("coinc_no_valid", {31'd0, valid}, 32'd0);
    chk("coinc_addr", imem_addr, 32'h0000_0200);

    // Redirect beats stall, then address wrap
    step(1'b0, 1'b0, 1'b0, 1'b1, $urandom, 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, $urandom, 32'hFFFF_FFFE);
    chk("wrap_start", imem_addr, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 1'b0, 1'b1, $urandom, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, $urandom, 32'd0);
    chk("wrap_zero", imem_addr, 32'h0000_0000);

    // Reset during DROP, late ready during reset
    step(1'b0, 1'b0, 1'b1, 1'b0, $urandom, 32'h0000_0040);
    step(1'b1, 1'b0, 1'b0, 1'b1, $urandom, 32'd0);
    chk("rst_drop_pc", pc, EXP_RESET_PC);
    chk("rst_drop_instr", instr, EXP_NOP);
    step(1'b1, 1'b0, 1'b0, 1'b1, $urandom, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, $urandom, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 2, $urandom_range(0, 1) == 1, $urandom_range(0, 99) < 15,
           $urandom_range(0, 99) < 40, $urandom, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Timing SHALL be one clock; reset is synchronous and active-high.
REQ-002 Parameter RESET_PC, 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-003 Parameter NOP_INSTR, 32'h0000_0013 (addi x0,x0,0), SHALL be the instr value while no valid instruction is held.
REQ-004 clk  in  1  SHALL be the rising-edge clock.
REQ-005 reset  in  1  SHALL be the synchronous active-high reset.
REQ-006 imem_req  out  1  SHALL be the instruction-memory read request.
REQ-007 imem_addr  out  32  SHALL be the word-aligned fetch address.
REQ-008 imem_ready  in  1  SHALL be the memory handshake: imem_rdata is valid this cycle.
REQ-009 imem_rdata  in  32  SHALL be the fetched instruction word.
REQ-010 stall  in  1  SHALL mean the downstream decode/control stage cannot accept the held instruction.
REQ-011 redirect  in  1  SHALL mean a taken branch or jump.
REQ-012 redirect_pc  in  32  SHALL be the redirect target.
REQ-013 valid  out  1  SHALL mean that instr, pc and the decoded fields are a real instruction.
REQ-014 pc  out  32  SHALL be the address of the held instruction.
REQ-015 instr  out  32  SHALL be the held instruction word.
REQ-016 opcode[6:0], rd[4:0], funct3[2:0], rs1[4:0], rs2[4:0], funct7[6:0]  out SHALL be combinational slices of instr: [6:0], [11:7], [14:12], [19:15], [24:20], [31:25].

Function
REQ-017 The FSM SHALL have three states: FETCH, HOLD and DROP.
REQ-018 In FETCH, imem_req=1 and imem_addr=pc; imem_addr SHALL remain stable until imem_ready.
REQ-019 In FETCH with imem_ready=1 and redirect=0: instr<=imem_rdata, valid<=1 and next state = HOLD, giving a latency of 1 cycle from imem_ready to valid.
REQ-020 In HOLD, imem_req SHALL be 0; with stall=1, pc, instr and valid SHALL hold unchanged.
REQ-021 In HOLD with stall=0 and redirect=0: pc<=pc+4 (mod 2^32, so 32'hFFFF_FFFC wraps to 0), valid<=0, instr<=NOP_INSTR, next state = FETCH.
REQ-022 Redirect in HOLD (with or without stall): pc<=redirect_pc, valid<=0, instr<=NOP_INSTR, next state = FETCH; redirect SHALL have priority over stall.
REQ-023 Redirect in FETCH in the same cycle as imem_ready: the returned data SHALL be discarded, pc<=redirect_pc, and the state SHALL stay FETCH.
REQ-024 Redirect in FETCH without imem_ready: redirect_pc SHALL be latched into pending_pc and next state = DROP.
REQ-025 In DROP, imem_req SHALL stay 1 on the old address; on imem_ready the data SHALL be discarded, pc<=pending_pc and next state = FETCH.
REQ-026 A further redirect in DROP SHALL overwrite pending_pc (the last redirect wins); if it coincides with imem_ready, pc<=the new redirect_pc.
REQ-027 redirect_pc[1:0] SHALL be forced to 2'b00 on capture.
REQ-028 imem_ready outside FETCH and DROP SHALL be ignored.
REQ-029 valid SHALL never be 1 for discarded data.

Reset
REQ-030 While reset=1: state=FETCH, pc=RESET_PC, pending_pc=RESET_PC, instr=NOP_INSTR, valid=0, and imem_req=0.
REQ-031 imem_req SHALL be 1 in the first cycle after reset deasserts.
REQ-032 Reset mid-request SHALL abandon the request; a late imem_ready SHALL be ignored.

Structure
REQ-033 Package rv32i_pkg SHALL hold the FSM state encoding, RESET_PC default, NOP_INSTR and the RV32I opcode constants shared with control_unit.
REQ-034 There SHALL be no sub-module; field slicing SHALL be inline.

Verification
REQ-035 Reset, then imem_ready=1 on every request, stall=0 -> fetch addresses 0,4,8; valid pulses every 2nd cycle; opcode=7'b0110011 for rdata 32'h0020_81B3.
REQ-036 stall=1 for 5 cycles while in HOLD -> instr and pc stable, imem_req=0 throughout.
REQ-037 redirect=1 with redirect_pc=32'h0000_0103 while a request is outstanding and imem_ready is delayed 3 cycles -> old data dropped, next imem_addr=32'h0000_0100, valid never 1 for the dropped word.
REQ-038 redirect coincident with imem_ready in FETCH -> no valid, next imem_addr=redirect target.
REQ-039 pc=32'hFFFF_FFFC accepted -> next imem_addr=32'h0000_0000.
REQ-040 reset asserted during DROP -> next cycle pc=RESET_PC, valid=0, instr=32'h0000_0013.
